// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between the fetch (I) and memory-stage (D) ports.
// D has priority, bounded by an anti-starvation limit for I; hung transactions time out with err.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SC_W = 4;
    localparam int unsigned TO_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            grant_d_c;
    logic            term_cnt_c;
    logic            txn_done_c;
    logic [DW-1:0]   done_rdata_c;

    // D wins unless I has been waiting through STARVE_MAX consecutive D grants
    assign grant_d_c    = d_req && (!i_req || (starve_cnt_q < SC_W'(STARVE_MAX)));
    assign term_cnt_c   = (to_cnt_q == TO_W'(TIMEOUT - 1));
    assign txn_done_c   = mem_ack || term_cnt_c;
    assign done_rdata_c = mem_ack ? mem_rdata : '0;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        to_cnt_d     = to_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        i_rdata      = '0;
        d_rdata      = '0;
        err          = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d_c) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    to_cnt_d    = '0;
                    if (!i_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q < SC_W'(STARVE_MAX)) begin
                        starve_cnt_d = starve_cnt_q + SC_W'(1);
                    end
                end else if (i_req) begin
                    state_d      = BUSY_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = i_addr;
                    to_cnt_d     = '0;
                    starve_cnt_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (txn_done_c) begin
                    // An ack on the terminal count still counts as a clean completion
                    err       = !mem_ack;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (state_q == BUSY_I) begin
                        i_ready = 1'b1;
                        i_rdata = done_rdata_c;
                    end else begin
                        d_ready = 1'b1;
                        d_rdata = done_rdata_c;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            to_cnt_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            to_cnt_q     <= to_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level model
// of the grant, starvation and timeout rules.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 4;
    localparam int unsigned TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ack;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ready, d_ready, err, mem_req, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    // Model state: consecutive D grants while I waited, and the last wdata driven to memory
    int          starve_m;
    logic [31:0] last_wd;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called while in an IDLE cycle before the next edge, with requests already driven.
    // ack_at: BUSY cycle (1-based) in which mem_ack is given; 0 or > TIMEOUT means never.
    task automatic run_slot(input int ack_at, input logic [31:0] rdv, input bit drop, input bit spur);
        int          g;
        logic [31:0] ea, ewd, erd;
        logic        ewe;
        bit          done, acked;
        mem_ack   = spur;
        mem_rdata = $urandom;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_i_ready", i_ready, 0);
        chk("idle_d_ready", d_ready, 0);
        chk("idle_err", err, 0);

        g = 0; ea = '0; ewe = 1'b0; ewd = last_wd;
        if (d_req && (!i_req || starve_m < int'(STARVE_MAX))) begin
            g = 2; ea = d_addr; ewe = d_we; ewd = d_wdata;
            if (!i_req) starve_m = 0;
            else if (starve_m < int'(STARVE_MAX)) starve_m = starve_m + 1;
        end else if (i_req) begin
            g = 1; ea = i_addr; ewe = 1'b0; ewd = last_wd;
            starve_m = 0;
        end
        last_wd = ewd;

        cyc();
        mem_ack = 1'b0;
        if (g == 0) begin
            chk("nogrant_busy", busy, 0);
            chk("nogrant_mem_req", mem_req, 0);
            return;
        end
        chk("grant_busy", busy, 1);
        chk("grant_mem_req", mem_req, 1);
        chk("grant_mem_addr", mem_addr, ea);
        chk("grant_mem_we", mem_we, ewe);
        chk("grant_mem_wdata", mem_wdata, ewd);

        for (int n = 1; n <= int'(TIMEOUT); n++) begin
            mem_ack   = (n == ack_at);
            mem_rdata = rdv;
            #1;
            acked = (n == ack_at);
            done  = acked || (n == int'(TIMEOUT));
            erd   = acked ? rdv : 32'h0;
            chk("busy_mem_req", mem_req, 1);
            chk("i_ready", i_ready, (done && g == 1) ? 1 : 0);
            chk("d_ready", d_ready, (done && g == 2) ? 1 : 0);
            chk("err", err, (done && !acked) ? 1 : 0);
            chk("i_rdata", i_rdata, (done && g == 1) ? erd : 32'h0);
            chk("d_rdata", d_rdata, (done && g == 2) ? erd : 32'h0);
            if (done) break;
            cyc();
        end

        cyc();
        mem_ack = 1'b0;
        if (drop) begin
            if (g == 1) i_req = 1'b0;
            else d_req = 1'b0;
        end
        chk("post_busy", busy, 0);
        chk("post_mem_req", mem_req, 0);
        chk("post_mem_we", mem_we, 0);
    endtask

    initial begin
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        starve_m = 0; last_wd = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ready", {i_ready, d_ready, err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Lone fetch, ack on the third BUSY cycle
        i_req = 1; i_addr = 32'h0040_0000;
        run_slot(3, 32'h8C01_0004, 1, 0);

        // Both requesting continuously with immediate acks: D,D,D,D,I,D
        i_req = 1; i_addr = 32'h0040_0004;
        d_req = 1; d_we = 1; d_addr = 32'h1001_0000; d_wdata = 32'hDEAD_BEEF;
        repeat (6) run_slot(1, $urandom, 0, 0);
        i_req = 0; d_req = 0;

        // Timeout on a load, then a normal access
        d_req = 1; d_we = 0; d_addr = 32'h1001_0010;
        run_slot(0, $urandom, 1, 0);
        d_req = 1; d_we = 0; d_addr = 32'h1001_0014;
        run_slot(2, 32'h1234_5678, 1, 0);

        // Ack exactly at the terminal count
        d_req = 1; d_we = 0; d_addr = 32'h1001_0018;
        run_slot(int'(TIMEOUT), 32'hCAFE_F00D, 1, 0);

        // Spurious ack with no requests pending
        run_slot(1, $urandom, 1, 1);

        // Async reset in the middle of a BUSY_D cycle
        d_req = 1; d_we = 1; d_addr = 32'h1001_0020; d_wdata = 32'h5555_AAAA;
        mem_ack = 0;
        cyc();
        chk("pre_rst_busy", busy, 1);
        mem_ack = 1;
        #1;
        chk("pre_rst_d_ready", d_ready, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_d_ready", d_ready, 0);
        chk("midrst_mem_wdata", mem_wdata, 0);
        mem_ack = 0;
        @(negedge clk);
        reset = 1'b0;
        starve_m = 0; last_wd = '0;
        run_slot(1, $urandom, 1, 0);

        // Randomized traffic
        for (int s = 0; s < 60; s++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            run_slot(int'($urandom_range(0, 18)), $urandom, 1, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port unified memory between the fetch stage (I-port, read-only) and the memory stage (D-port, read/write) of the 5-stage pipeline.
- Each port sees a request/ready handshake. The fetch and memory stages derive their StallF and stall-M terms from req & ~ready.
- Data accesses have priority, with an anti-starvation limit for fetch. A timeout aborts hung memory transactions and flags an error.

Parameters:
- STARVE_MAX, 4: consecutive D grants allowed while i_req is pending before I must be granted; legal range 1..15.
- TIMEOUT, 16: BUSY cycles without mem_ack before the transaction is aborted; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  32  fetch word address
- i_ready  out  1  fetch complete this cycle (combinational from state/mem_ack/timeout)
- i_rdata  out  32  fetch data, valid when i_ready & ~err
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_ready  out  1  data access complete this cycle
- d_rdata  out  32  load data, valid when d_ready & ~err
- err  out  1  asserted with i_ready/d_ready when the transaction timed out
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  32  registered address
- mem_wdata  out  32  registered write data
- mem_ack  in  1  memory completes the current transaction; read data valid this cycle
- mem_rdata  in  32  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; starve_cnt=0; to_cnt=0; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; i_ready=d_ready=err=0.
- Reset mid-transaction: the transaction is dropped with no ready pulse.
- States are IDLE, BUSY_I, BUSY_D.
- IDLE grant decision, evaluated each cycle and registered at the edge:
  - Grant D if d_req & (~i_req | starve_cnt<STARVE_MAX).
  - Else grant I if i_req.
  - Else stay IDLE.
- On a grant:
  - Latch mem_addr (and, for D, mem_we=d_we and mem_wdata=d_wdata; for I, mem_we=0 and mem_wdata unchanged).
  - Set mem_req=1, to_cnt=0, and enter BUSY_I or BUSY_D.
- starve_cnt update on a grant:
  - D grant with i_req=1: starve_cnt+1, saturating at STARVE_MAX.
  - D grant with i_req=0: starve_cnt=0.
  - I grant: starve_cnt=0.
- BUSY_x:
  - mem_req stays 1; address and data are stable.
  - If mem_ack: x_ready=1 in the same cycle, x_rdata=mem_rdata, err=0; next state IDLE with mem_req=0 and mem_we=0.
  - Else if to_cnt==TIMEOUT-1: x_ready=1, err=1, rdata=0; next state IDLE with mem_req=0 and mem_we=0.
  - Else to_cnt+1.
- Minimum latency is 3 cycles per access: grant edge, mem_req cycle with ack, then IDLE for one cycle before the next grant. The requester changes or drops req after seeing ready, so no re-grant is possible.
- Back-to-back accesses: an IDLE cycle always separates transactions; no zero-gap pipelining.
- The non-granted requester sees ready=0 throughout and is stalled.
- mem_ack in IDLE is ignored. mem_ack in the same cycle as the timeout terminal count is treated as a normal completion (err=0).
- Dropping req while BUSY is illegal. The arbiter still completes the transaction and pulses ready.
- The ready of the non-active port is always 0. i_rdata and d_rdata are 0 when their ready is 0.

Test Plan:
- Lone fetch: i_req=1, addr=0x00400000, mem_ack two cycles after mem_req rises, mem_rdata=0x8C010004. Required: mem_addr=0x00400000, mem_we=0, i_ready=1 with i_rdata=0x8C010004 in the ack cycle, busy falls next cycle.
- Simultaneous i_req and d_req (store, addr 0x10010000, data 0xDEADBEEF), immediate acks, both held continuously. Required: the first 4 grants go to D (mem_we=1, data 0xDEADBEEF), the 5th to I, the 6th to D; starve_cnt returns to 0 after the I grant.
- Timeout: d_req load, mem_ack never asserted, TIMEOUT=16. Required: d_ready=1 and err=1 on the 16th BUSY cycle, d_rdata=0, then IDLE; the next request is served normally with err=0.
- Ack at the terminal cycle: mem_ack asserted on the 16th BUSY cycle. Required: d_ready=1, err=0, d_rdata=mem_rdata.
- Async reset asserted mid BUSY_D (between clock edges). Required: mem_req, busy and d_ready go to 0 immediately. After release with d_req still high, a fresh grant occurs at the next edge.
- Spurious mem_ack in IDLE with no requests. Required: no ready pulse, state remains IDLE.
